// File: rtl/mux2_arbiter_if.sv
// Shared-channel bus between two requesters and the 2:1 arbiter.
interface mux2_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic              gnt0;
  logic              gnt1;
  logic              select;
  logic [DATA_W-1:0] out;
  logic              out_valid;

  // Requester side: drives requests/data, observes grants and the channel.
  modport master (
    output req0, req1, in0, in1,
    input  gnt0, gnt1, select, out, out_valid
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, in0, in1,
    output gnt0, gnt1, select, out, out_valid
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter with bounded hold and a registered
// shared data channel (one-cycle transfer latency).
module mux2_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  // Counter saturates here; reaching it with the other side waiting forces a handoff.
  localparam logic [3:0] HOLD_TOP = 4'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  hold, hold_nxt;
  logic        last;
  logic        xfer;

  assign xfer = (state == GRANT0 && bus.req0) || (state == GRANT1 && bus.req1);

  // Next-state and hold-counter decisions.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = last ? GRANT0 : GRANT1;
        else if (bus.req0)        state_nxt = GRANT0;
        else if (bus.req1)        state_nxt = GRANT1;
      end
      GRANT0: begin
        if (!bus.req0)                      state_nxt = bus.req1 ? GRANT1 : IDLE;
        else if (bus.req1 && hold == HOLD_TOP) state_nxt = GRANT1;
      end
      GRANT1: begin
        if (!bus.req1)                      state_nxt = bus.req0 ? GRANT0 : IDLE;
        else if (bus.req0 && hold == HOLD_TOP) state_nxt = GRANT0;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state)  hold_nxt = '0;
    else if (xfer)           hold_nxt = (hold == HOLD_TOP) ? hold : hold + 4'd1;
  end

  // Arbitration state; last-served starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      if (state_nxt == GRANT0)      last <= 1'b0;
      else if (state_nxt == GRANT1) last <= 1'b1;
    end
  end

  // Data channel: capture the granted input on a live transfer, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= xfer;
      if (xfer) bus.out <= (state == GRANT1) ? bus.in1 : bus.in0;
    end
  end

  assign bus.gnt0   = (state == GRANT0);
  assign bus.gnt1   = (state == GRANT1);
  assign bus.select = last;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench: expected channel data is queued when a transfer is
// driven and retired when the arbiter presents it one cycle later.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  mux2_arbiter_if #(.DATA_W(8)) ifa ();
  mux2_arbiter_if #(.DATA_W(8)) ifb ();

  mux2_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mux2_arbiter #(.DATA_W(8), .MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    checks++; if (ifa.gnt0 !== 1'b0 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b%b want 00", ifa.gnt0, ifa.gnt1); end
    checks++; if (ifa.out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", ifa.out); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifa.out_valid); end
    checks++; if (ifa.select !== 1'b1) begin errors++; $display("FAIL reset_select got %b want 1", ifa.select); end
    checks++; if (ifb.gnt0 !== 1'b0 || ifb.select !== 1'b1) begin errors++; $display("FAIL reset_b got gnt0=%b sel=%b want 0 1", ifb.gnt0, ifb.select); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    ifa.req0 = 1'b1; ifa.in0 = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) qa.push_back(ifa.in0);
      tick();
      checks++; if (ifa.gnt0 !== 1'b1 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt cyc %0d got %b%b want 10", i, ifa.gnt0, ifa.gnt1); end
      checks++; if (ifa.select !== 1'b0) begin errors++; $display("FAIL single_select got %b want 0", ifa.select); end
      checks++; if (ifa.out_valid !== 1'(qa.size() != 0)) begin errors++; $display("FAIL single_valid cyc %0d got %b want %b", i, ifa.out_valid, qa.size() != 0); end
      if (qa.size() != 0) begin
        exp_d = qa.pop_front();
        checks++; if (ifa.out !== exp_d) begin errors++; $display("FAIL single_out got %h want %h", ifa.out, exp_d); end
      end
    end
    ifa.req0 = 1'b0;
    tick();
    checks++; if (ifa.gnt0 !== 1'b0 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got gnt0=%b v=%b want 0 0", ifa.gnt0, ifa.out_valid); end
    checks++; if (ifa.out !== 8'hA5) begin errors++; $display("FAIL single_hold_out got %h want a5", ifa.out); end
  endtask

  task automatic test_tie;
    logic g0c, g1c, e0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      g0c = (n > 1) && ((((n - 2) / 4) % 2) == 0);
      g1c = (n > 1) && !g0c;
      ifa.in0 = 8'($urandom); ifa.in1 = 8'($urandom);
      if (g0c) qa.push_back(ifa.in0);
      if (g1c) qa.push_back(ifa.in1);
      tick();
      e0 = ((((n - 1) / 4) % 2) == 0);
      checks++; if (ifa.gnt0 !== e0 || ifa.gnt1 !== !e0) begin errors++; $display("FAIL tie_gnt edge %0d got %b%b want %b%b", n, ifa.gnt0, ifa.gnt1, e0, !e0); end
      checks++; if (ifa.out_valid !== 1'(qa.size() != 0)) begin errors++; $display("FAIL tie_valid edge %0d got %b", n, ifa.out_valid); end
      if (qa.size() != 0) begin
        exp_d = qa.pop_front();
        checks++; if (ifa.out !== exp_d) begin errors++; $display("FAIL tie_out edge %0d got %h want %h", n, ifa.out, exp_d); end
      end
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    tick();
    checks++; if (ifa.gnt0 !== 1'b0 || ifa.gnt1 !== 1'b0 || ifa.out_valid !== 1'b0) begin errors++; $display("FAIL tie_idle got %b%b v=%b want 00 0", ifa.gnt0, ifa.gnt1, ifa.out_valid); end
  endtask

  task automatic test_hold;
    ifa.req0 = 1'b1; ifa.req1 = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      ifa.in0 = 8'(n * 7 + 3);
      if (n > 1) qa.push_back(ifa.in0);
      tick();
      checks++; if (ifa.gnt0 !== 1'b1 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL hold_gnt edge %0d got %b%b want 10", n, ifa.gnt0, ifa.gnt1); end
      checks++; if (ifa.out_valid !== 1'(qa.size() != 0)) begin errors++; $display("FAIL hold_valid edge %0d got %b", n, ifa.out_valid); end
      if (qa.size() != 0) begin
        exp_d = qa.pop_front();
        checks++; if (ifa.out !== exp_d) begin errors++; $display("FAIL hold_out edge %0d got %h want %h", n, ifa.out, exp_d); end
      end
    end
  endtask

  task automatic test_back_to_back;
    // Leave GRANT0 for GRANT1, stream on 1, then hand straight back to 0.
    ifa.req0 = 1'b0; ifa.req1 = 1'b1; ifa.in1 = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) begin ifa.in1 = 8'(8'h60 + n); qa.push_back(ifa.in1); end
      tick();
      checks++; if (ifa.gnt1 !== 1'b1 || ifa.gnt0 !== 1'b0) begin errors++; $display("FAIL b2b_gnt1 cyc %0d got %b%b want 01", n, ifa.gnt0, ifa.gnt1); end
      checks++; if (ifa.out_valid !== 1'(qa.size() != 0)) begin errors++; $display("FAIL b2b_valid1 cyc %0d got %b", n, ifa.out_valid); end
      if (qa.size() != 0) begin
        exp_d = qa.pop_front();
        checks++; if (ifa.out !== exp_d) begin errors++; $display("FAIL b2b_out1 got %h want %h", ifa.out, exp_d); end
      end
    end
    ifa.req1 = 1'b1; ifa.in1 = 8'h6F; qa.push_back(ifa.in1);
    tick();
    ifa.req1 = 1'b0; ifa.req0 = 1'b1; ifa.in0 = 8'h3C;
    exp_d = qa.pop_front();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out !== exp_d) begin errors++; $display("FAIL b2b_last1 got v=%b %h want 1 %h", ifa.out_valid, ifa.out, exp_d); end
    for (int n = 0; n < 3; n++) begin
      if (n > 0) begin ifa.in0 = 8'(8'h3C + n); qa.push_back(ifa.in0); end
      tick();
      checks++; if (ifa.gnt0 !== 1'b1 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL b2b_gnt0 cyc %0d got %b%b want 10", n, ifa.gnt0, ifa.gnt1); end
      checks++; if (ifa.out_valid !== 1'(qa.size() != 0)) begin errors++; $display("FAIL b2b_valid0 cyc %0d got %b", n, ifa.out_valid); end
      if (qa.size() != 0) begin
        exp_d = qa.pop_front();
        checks++; if (ifa.out !== exp_d) begin errors++; $display("FAIL b2b_out0 got %h want %h", ifa.out, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid;
    ifa.req0 = 1'b0; ifa.req1 = 1'b1; ifa.in1 = 8'h77;
    tick();
    checks++; if (ifa.gnt1 !== 1'b1) begin errors++; $display("FAIL rmid_enter got gnt1=%b want 1", ifa.gnt1); end
    qa.push_back(ifa.in1);
    tick();
    exp_d = qa.pop_front();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out !== exp_d) begin errors++; $display("FAIL rmid_xfer got v=%b %h want 1 %h", ifa.out_valid, ifa.out, exp_d); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifa.gnt1 !== 1'b0 || ifa.gnt0 !== 1'b0) begin errors++; $display("FAIL rmid_async_gnt got %b%b want 00", ifa.gnt0, ifa.gnt1); end
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out !== 8'h00) begin errors++; $display("FAIL rmid_async_out got v=%b %h want 0 00", ifa.out_valid, ifa.out); end
    checks++; if (ifa.select !== 1'b1) begin errors++; $display("FAIL rmid_async_select got %b want 1", ifa.select); end
    tick();
    checks++; if (ifa.out_valid !== 1'b0 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL rmid_held got v=%b gnt1=%b want 0 0", ifa.out_valid, ifa.gnt1); end
    rst_n = 1'b1;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    tick();
    checks++; if (ifa.gnt0 !== 1'b1 || ifa.gnt1 !== 1'b0) begin errors++; $display("FAIL rmid_first_tie got %b%b want 10", ifa.gnt0, ifa.gnt1); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_valid got %b want 0", ifa.out_valid); end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    tick();
  endtask

  task automatic test_maxhold1;
    logic g0c, e0;
    ifb.req0 = 1'b1; ifb.req1 = 1'b1; ifb.in0 = 8'h11; ifb.in1 = 8'h22;
    for (int n = 1; n <= 8; n++) begin
      g0c = ((n - 2) % 2) == 0;
      if (n > 1) qb.push_back(g0c ? ifb.in0 : ifb.in1);
      tick();
      e0 = (n % 2) == 1;
      checks++; if (ifb.gnt0 !== e0 || ifb.gnt1 !== !e0) begin errors++; $display("FAIL mh1_gnt edge %0d got %b%b want %b%b", n, ifb.gnt0, ifb.gnt1, e0, !e0); end
      checks++; if (ifb.out_valid !== 1'(qb.size() != 0)) begin errors++; $display("FAIL mh1_valid edge %0d got %b", n, ifb.out_valid); end
      if (qb.size() != 0) begin
        exp_d = qb.pop_front();
        checks++; if (ifb.out !== exp_d) begin errors++; $display("FAIL mh1_out edge %0d got %h want %h", n, ifb.out, exp_d); end
      end
    end
    ifb.req0 = 1'b0; ifb.req1 = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.in0 = '0; ifa.in1 = '0;
    ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.in0 = '0; ifb.in1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_maxhold1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
